// File: rtl/mmio_gpio.sv
// GPIO slot for the MCS MMIO bus: per-pin direction, synchronised inputs,
// rise/fall edge capture into sticky write-1-to-clear status, level irq.
module mmio_gpio #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cs,
    input  logic         write,
    input  logic         read,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] gpio_in,
    output logic [W-1:0] gpio_out,
    output logic [W-1:0] gpio_oe,
    output logic         irq
);

    localparam logic [4:0] A_DOUT = 5'd0;
    localparam logic [4:0] A_DIR  = 5'd1;
    localparam logic [4:0] A_DIN  = 5'd2;
    localparam logic [4:0] A_REN  = 5'd3;
    localparam logic [4:0] A_FEN  = 5'd4;
    localparam logic [4:0] A_STAT = 5'd5;

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0] prev_q, dout_q, dir_q, ren_q, fen_q, stat_q;
    logic [W-1:0] stat_d, data_in, rise, fall, clr;
    logic         irq_q;
    logic         wr_en;

    // Reads have no side effects, so the strobe is intentionally unused.
    logic unused_read;
    assign unused_read = read;

    assign wr_en   = cs & write;
    assign data_in = sync_q[SYNC_STAGES-1];
    assign rise    = data_in & ~prev_q;
    assign fall    = ~data_in & prev_q;

    // Status next-state: clear first, then OR in new edges so a set wins a race.
    always_comb begin
        clr = '0;
        if (wr_en && addr == A_STAT) clr = wr_data[W-1:0];
        stat_d = (stat_q & ~clr) | (rise & ren_q) | (fall & fen_q);
    end

    // Input synchroniser chain plus one-cycle delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= data_in;
        end
    end

    // Software-writable configuration registers; only the low W bits are kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
            dir_q  <= '0;
            ren_q  <= '0;
            fen_q  <= '0;
        end else if (wr_en) begin
            case (addr)
                A_DOUT:  dout_q <= wr_data[W-1:0];
                A_DIR:   dir_q  <= wr_data[W-1:0];
                A_REN:   ren_q  <= wr_data[W-1:0];
                A_FEN:   fen_q  <= wr_data[W-1:0];
                default: ;
            endcase
        end
    end

    // Sticky edge status and the registered interrupt that follows it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= stat_d;
            irq_q  <= |stat_q;
        end
    end

    // Zero-latency read mux; unselected slot and unmapped addresses read 0.
    always_comb begin
        rd_data = '0;
        if (cs) begin
            case (addr)
                A_DOUT:  rd_data = 32'(dout_q);
                A_DIR:   rd_data = 32'(dir_q);
                A_DIN:   rd_data = 32'(data_in);
                A_REN:   rd_data = 32'(ren_q);
                A_FEN:   rd_data = 32'(fen_q);
                A_STAT:  rd_data = 32'(stat_q);
                default: rd_data = '0;
            endcase
        end
    end

    assign gpio_out = dout_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio (W=8, SYNC_STAGES=2) with hand-computed expectations.
module tb_mmio_gpio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs, write, read;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic [7:0]  gpio_in, gpio_out, gpio_oe;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    mmio_gpio #(.W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .write(write), .read(read),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One bus write; returns 1 time unit after the write edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(posedge clk);
        #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        chk(tag, rd_data, exp);
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0;
        addr = '0; wr_data = '0; gpio_in = '0;
        cyc(2);
        chk("rst_out", {24'd0, gpio_out}, 32'h0);
        chk("rst_oe",  {24'd0, gpio_oe},  32'h0);
        chk("rst_irq", {31'd0, irq},      32'h0);
        @(negedge clk); reset_n = 1'b1;

        // Build up DATA_OUT=FF and STATUS=0F, then reset mid-run.
        wr(5'd0, 32'hFF);
        chk("dout_ff", {24'd0, gpio_out}, 32'hFF);
        wr(5'd3, 32'h0F);
        @(negedge clk); gpio_in = 8'h0F;
        cyc(4);
        rd("stat_0f", 5'd5, 32'h0F);
        chk("irq_pre_rst", {31'd0, irq}, 32'h1);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out", {24'd0, gpio_out}, 32'h0);
        chk("midrst_irq", {31'd0, irq},      32'h0);
        rd("midrst_stat", 5'd5, 32'h0);
        gpio_in = 8'h00;
        cyc(1);
        @(negedge clk); reset_n = 1'b1;
        #1;
        for (int a = 0; a < 6; a++) rd($sformatf("post_rst_a%0d", a), 5'(a), 32'h0);

        // Output path.
        wr(5'd1, 32'hA5);
        chk("oe_a5", {24'd0, gpio_oe}, 32'hA5);
        wr(5'd0, 32'h3C);
        chk("out_3c", {24'd0, gpio_out}, 32'h3C);
        wr(5'd0, 32'hFFFF_FF3C);
        rd("dout_trunc", 5'd0, 32'h3C);

        // Input latency: change before edge k, visible after edge k+1.
        @(negedge clk); gpio_in = 8'h01;
        cyc(1);
        rd("din_k", 5'd2, 32'h00);
        cyc(1);
        rd("din_k1", 5'd2, 32'h01);

        // Edge detect: enables, then settle pin1 high / pin0 low with no flags.
        wr(5'd3, 32'h01);
        wr(5'd4, 32'h02);
        @(negedge clk); gpio_in = 8'h02;
        cyc(4);
        rd("no_flag", 5'd5, 32'h00);
        chk("no_irq", {31'd0, irq}, 32'h0);
        @(negedge clk); gpio_in = 8'h01;
        cyc(1);
        rd("edge_k", 5'd5, 32'h00);
        cyc(1);
        rd("edge_k1", 5'd5, 32'h00);
        cyc(1);
        rd("edge_k2", 5'd5, 32'h03);
        chk("irq_k2", {31'd0, irq}, 32'h0);
        cyc(1);
        chk("irq_k3", {31'd0, irq}, 32'h1);
        wr(5'd5, 32'h03);
        rd("w1c_all", 5'd5, 32'h00);
        chk("irq_hold", {31'd0, irq}, 32'h1);
        cyc(1);
        chk("irq_clr", {31'd0, irq}, 32'h0);

        // W1C race: fall on pin0 (not enabled), then rise coinciding with a clear.
        @(negedge clk); gpio_in = 8'h00;
        cyc(4);
        @(negedge clk); gpio_in = 8'h01;
        cyc(4);
        rd("race_pre", 5'd5, 32'h01);
        @(negedge clk); gpio_in = 8'h00;
        cyc(4);
        @(negedge clk); gpio_in = 8'h01;
        @(posedge clk);
        @(posedge clk);
        wr(5'd5, 32'h01);
        rd("race_set_wins", 5'd5, 32'h01);
        wr(5'd5, 32'h01);
        rd("race_clr", 5'd5, 32'h00);
        cyc(1);
        chk("race_irq", {31'd0, irq}, 32'h0);

        // Unmapped access and deselected reads.
        wr(5'd9, 32'hDEAD_BEEF);
        rd("unmap_a9", 5'd9, 32'h0);
        rd("unmap_a0", 5'd0, 32'h3C);
        rd("unmap_a1", 5'd1, 32'hA5);
        rd("unmap_a3", 5'd3, 32'h01);
        rd("unmap_a4", 5'd4, 32'h02);
        addr = 5'd1; cs = 1'b0;
        #1 chk("cs0_a1", rd_data, 32'h0);
        addr = 5'd0;
        #1 chk("cs0_a0", rd_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_gpio.md
# mmio_gpio

Parametrised general-purpose I/O slot for the MCS MMIO subsystem, the successor to the fixed output-only GPO slot. It provides per-pin direction control, synchronised input sampling, per-pin rising/falling edge detection with sticky write-1-to-clear status, and a level interrupt. It attaches to one slot of the MMIO controller; the controller performs slot decode and presents a word address within the slot.

## Interface

Parameters:
- W, 8, pin count, legal range 1..32
- SYNC_STAGES, 2, input synchroniser depth, legal range 2..4

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low
- cs  in  1  slot select from the MMIO controller
- write  in  1  write strobe, qualified by cs
- read  in  1  read strobe, qualified by cs
- addr  in  5  word address within the slot
- wr_data  in  32  write data
- rd_data  out  32  read data
- gpio_in  in  W  asynchronous pin inputs
- gpio_out  out  W  output pin values, driven from the DATA_OUT register
- gpio_oe  out  W  output enable per pin; 1 = output, driven from DIR
- irq  out  1  level interrupt, registered

## Operation

Register map (addr):
- 0 DATA_OUT, rw: drives gpio_out.
- 1 DIR, rw: drives gpio_oe.
- 2 DATA_IN, ro: synchronised gpio_in. Pins configured as outputs still read their pad value.
- 3 RISE_EN, rw: per-pin rising-edge enable.
- 4 FALL_EN, rw: per-pin falling-edge enable.
- 5 STATUS, read / write-1-to-clear: sticky edge flags.
- 6..31: read 0; writes are ignored.

Access rules:
- A write occurs at a clk edge when cs & write; only bits [W-1:0] are stored.
- rd_data is combinational: when cs = 1, it carries the addressed register, zero-extended; when cs = 0, it is 0. The read strobe has no side effects.

Input path:
- gpio_in feeds a SYNC_STAGES flop chain; the last stage is DATA_IN.
- A prev register holds DATA_IN delayed by one cycle.
- rise = DATA_IN & ~prev; fall = ~DATA_IN & prev.

Status update, per bit, each cycle:
- next = (status & ~clr) | (rise & RISE_EN) | (fall & FALL_EN)
- clr = wr_data[W-1:0] when writing addr 5, otherwise 0.
- If a set and a clear hit the same bit in the same cycle, the set wins.
- Changing an enable does not alter existing status bits.

Interrupt:
- irq is registered: irq <= |status.

Reset (asynchronous, reset_n = 0): all registers go to 0.
- Synchroniser, prev, DATA_OUT, DIR, RISE_EN, FALL_EN, STATUS and irq are 0.
- Outputs during reset: gpio_out = 0, gpio_oe = 0 (all inputs), irq = 0, and rd_data per the combinational rule.
- Reset asserted mid-operation discards pending edges immediately.
- A pin held high through reset release produces a rise one cycle after it reaches DATA_IN. The flag is recorded only if RISE_EN is already set, and RISE_EN is 0 after reset, so no spurious flag occurs.

## Timing

- Write: the register updates at the clk edge where cs & write. gpio_out and gpio_oe change at that same edge.
- Read: zero-latency combinational path from addr and cs.
- Input latency: a gpio_in change set up before edge k appears in DATA_IN after edge k+SYNC_STAGES-1.
- Edge flag: the matching STATUS bit sets at edge k+SYNC_STAGES.
- Interrupt: irq asserts at edge k+SYNC_STAGES+1.
- Pulse width: pulses shorter than one clk period may be missed. Each transition that survives synchronisation sets the flag exactly once.
- irq clear: irq deasserts one edge after the last STATUS bit is cleared.

## Test plan

1. Reset state: assert reset_n = 0 mid-run with DATA_OUT = 0xFF and STATUS = 0x0F -> all outputs 0 immediately; reads of addr 0..5 return 0 after reset release.
2. Output path: write DIR = 0xA5, then DATA_OUT = 0x3C -> gpio_oe = 0xA5 and gpio_out = 0x3C on the write edge. Write 0xFFFF_FF3C with W = 8 -> addr 0 reads 0x0000_003C.
3. Input latency: with SYNC_STAGES = 2, raise gpio_in[0] before edge k -> DATA_IN reads 0x01 after edge k+1, not before.
4. Edge detect: set RISE_EN = 0x01 and FALL_EN = 0x02; toggle pin0 0→1 and pin1 1→0 -> STATUS = 0x03 at edge k+2 and irq = 1 at k+3. A falling edge on pin0 sets nothing.
5. W1C race: with STATUS[0] = 1, write 0x01 to addr 5 in the same cycle a new enabled rise on pin0 is detected -> STATUS[0] remains 1. Then write 0x01 with no edge -> STATUS = 0 and irq = 0 one edge later.
6. Unmapped access: write 0xDEAD_BEEF to addr 9 -> no register changes and addr 9 reads 0. With cs = 0, rd_data = 0 for any addr.
